// File: rtl/vga_fetch_scheduler_if.sv
// AXI4 read-address and read-data channel bundle between the VGA line-buffer
// fetch scheduler (master) and the SDRAM interconnect (slave).
interface vga_fetch_scheduler_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  // Read address channel
  logic [ADDR_WIDTH-1:0] araddr_o;
  logic [7:0]            arlen_o;
  logic [2:0]            arsize_o;
  logic [1:0]            arburst_o;
  logic                  arvalid_o;
  logic                  arready_i;
  // Read data channel
  logic                  rvalid_i;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic [1:0]            rresp_i;
  logic                  rlast_i;
  logic                  rready_o;

  modport master (
    output araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o,
    input  arready_i, rvalid_i, rdata_i, rresp_i, rlast_i
  );

  modport slave (
    input  araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o,
    output arready_i, rvalid_i, rdata_i, rresp_i, rlast_i
  );
endinterface

// File: rtl/vga_fetch_scheduler.sv
// Ping/pong line-buffer fetch scheduler: issues one fixed-length INCR read
// burst per free buffer half, walks the frame buffer with wrap-around and
// steers returned beats into the half being filled.
module vga_fetch_scheduler #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 32,
  parameter int BEAT_BYTES = 8
) (
  input  logic                         clk_a,
  input  logic                         reset_a,
  input  logic                         enable_i,
  input  logic [ADDR_WIDTH-1:0]        base_addr_i,
  input  logic [ADDR_WIDTH-1:0]        top_addr_i,
  input  logic                         release_i,
  input  logic                         release_sel_i,
  vga_fetch_scheduler_if.master        axi,
  output logic                         wr_en_o,
  output logic                         wr_sel_o,
  output logic [$clog2(BURST_LEN)-1:0] wr_idx_o,
  output logic [DATA_WIDTH-1:0]        wr_data_o,
  output logic [1:0]                   buf_full_o,
  output logic                         busy_o,
  output logic                         err_o
);
  localparam int IDX_W = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BURST_LEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  init_q, init_d;
  logic                  fill_sel_q, fill_sel_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] top_q, top_d;
  logic [IDX_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [1:0]            buf_full_q, buf_full_d;
  logic                  err_q, err_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  rready_q, rready_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wr_sel_q, wr_sel_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;

  logic [ADDR_WIDTH-1:0] addr_sum_s;
  logic                  beat_ok_s;
  logic                  last_beat_s;

  // Burst constants never change
  assign axi.arlen_o   = 8'(BURST_LEN - 1);
  assign axi.arsize_o  = 3'($clog2(BEAT_BYTES));
  assign axi.arburst_o = 2'b01;

  assign axi.araddr_o  = araddr_q;
  assign axi.arvalid_o = arvalid_q;
  assign axi.rready_o  = rready_q;
  assign wr_en_o       = wr_en_q;
  assign wr_sel_o      = wr_sel_q;
  assign wr_idx_o      = wr_idx_q;
  assign wr_data_o     = wr_data_q;
  assign buf_full_o    = buf_full_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

  // Next-state logic: FSM, address walk, beat steering and buffer flags
  always_comb begin
    state_d     = state_q;
    init_d      = 1'b0;
    fill_sel_d  = fill_sel_q;
    next_addr_d = next_addr_q;
    top_d       = top_q;
    beat_cnt_d  = beat_cnt_q;
    buf_full_d  = buf_full_q;
    err_d       = err_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    rready_d    = rready_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    addr_sum_s  = next_addr_q + STRIDE;
    beat_ok_s   = axi.rvalid_i & rready_q;
    last_beat_s = (beat_cnt_q == LAST_IDX);

    // Release first so a same-cycle DONE set on the other half still lands
    if (release_i) begin
      buf_full_d[release_sel_i] = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end

    case (state_q)
      IDLE: begin
        if (init_q || !enable_i) begin
          // Reload point: restart the walk and forget all buffer state
          next_addr_d = base_addr_i;
          top_d       = top_addr_i;
          buf_full_d  = 2'b00;
          fill_sel_d  = 1'b0;
          err_d       = 1'b0;
        end else if (!buf_full_q[fill_sel_q]) begin
          state_d   = ADDR;
          arvalid_d = 1'b1;
          araddr_d  = next_addr_q;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (arvalid_q && axi.arready_i) begin
          state_d    = DATA;
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          beat_cnt_d = '0;
          if (addr_sum_s >= top_q) begin
            next_addr_d = base_addr_i;
            top_d       = top_addr_i;
          end else begin
            next_addr_d = addr_sum_s;
          end
        end else if (!enable_i) begin
          // No handshake yet, so the request can be withdrawn
          state_d   = IDLE;
          arvalid_d = 1'b0;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (beat_ok_s) begin
          beat_cnt_d = beat_cnt_q + IDX_W'(1);
          wr_en_d    = (axi.rresp_i == 2'b00);
          wr_sel_d   = fill_sel_q;
          wr_idx_d   = beat_cnt_q;
          wr_data_d  = axi.rdata_i;
          if ((axi.rresp_i != 2'b00) || (axi.rlast_i != last_beat_s)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (last_beat_s) begin
            state_d  = DONE;
            rready_d = 1'b0;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        buf_full_d[fill_sel_q] = 1'b1;
        fill_sel_d             = ~fill_sel_q;
        state_d                = IDLE;
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk_a or posedge reset_a) begin
    if (reset_a) begin
      state_q     <= IDLE;
      init_q      <= 1'b1;
      fill_sel_q  <= 1'b0;
      next_addr_q <= '0;
      top_q       <= '0;
      beat_cnt_q  <= '0;
      buf_full_q  <= 2'b00;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      fill_sel_q  <= fill_sel_d;
      next_addr_q <= next_addr_d;
      top_q       <= top_d;
      beat_cnt_q  <= beat_cnt_d;
      buf_full_q  <= buf_full_d;
      err_q       <= err_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end
endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Self-checking bench for vga_fetch_scheduler: directed bursts against a
// transaction-level model of the address walk and the expected buffer writes.
module tb_vga_fetch_scheduler;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BL = 32;
  localparam int BB = 8;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          release_p;
  logic          release_sel;
  logic [AW-1:0] base;
  logic [AW-1:0] top;
  logic          wr_en;
  logic          wr_sel;
  logic [IW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic [1:0]    buf_full;
  logic          busy;
  logic          err;

  vga_fetch_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vga_fetch_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .BEAT_BYTES(BB)
  ) dut (
    .clk_a        (clk),
    .reset_a      (rst),
    .enable_i     (enable),
    .base_addr_i  (base),
    .top_addr_i   (top),
    .release_i    (release_p),
    .release_sel_i(release_sel),
    .axi          (bus),
    .wr_en_o      (wr_en),
    .wr_sel_o     (wr_sel),
    .wr_idx_o     (wr_idx),
    .wr_data_o    (wr_data),
    .buf_full_o   (buf_full),
    .busy_o       (busy),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- model ----------------
  typedef struct packed {
    logic          sel;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr [0:1023];
  int            wp = 0;
  int            rp = 0;
  int            flush_cnt = 0;
  int            flush_seen = 0;
  int            reload_cnt = 0;
  int            reload_seen = 0;
  int            wr_seen = 0;
  logic [AW-1:0] mdl_base;
  logic [AW-1:0] mdl_top;
  logic [AW-1:0] mdl_addr = '0;
  logic          mdl_sel;
  logic [AW-1:0] seen_addr [$];

  // Frame-buffer walk: one burst of BL*BB bytes, back to base at or past top
  function automatic logic [AW-1:0] mdl_step(logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a + 64'(BL * BB);
    return (s >= mdl_top) ? mdl_base : s;
  endfunction

  // Compare process: AR requests and buffer writes, every cycle
  initial begin
    logic          prev_arvalid;
    logic          prev_arready;
    logic [AW-1:0] prev_araddr;
    wr_t           e;
    prev_arvalid = 1'b0;
    prev_arready = 1'b0;
    prev_araddr  = '0;
    forever begin
      @(negedge clk);
      if (reload_cnt != reload_seen) begin
        reload_seen = reload_cnt;
        mdl_addr    = mdl_base;
      end
      if (flush_cnt != flush_seen) begin
        flush_seen = flush_cnt;
        rp         = wp;
      end
      if (!rst) begin
        if (bus.arvalid_o && prev_arvalid && !prev_arready)
          check("ar_stable", bus.araddr_o, prev_araddr);
        if (bus.arvalid_o && bus.arready_i) begin
          check("araddr", bus.araddr_o, mdl_addr);
          check("arlen", 64'(bus.arlen_o), 64'd31);
          check("arsize", 64'(bus.arsize_o), 64'd3);
          check("arburst", 64'(bus.arburst_o), 64'd1);
          seen_addr.push_back(bus.araddr_o);
          mdl_addr = mdl_step(mdl_addr);
        end
        if (wr_en) begin
          wr_seen++;
          if (rp == wp) begin
            check("wr_unexpected", 64'(wr_idx), 64'hFFFF);
          end else begin
            e = exp_wr[rp];
            rp++;
            check("wr_sel", 64'(wr_sel), 64'(e.sel));
            check("wr_idx", 64'(wr_idx), 64'(e.idx));
            check("wr_data", wr_data, e.data);
          end
        end
        prev_arvalid = bus.arvalid_o;
        prev_arready = bus.arready_i;
        prev_araddr  = bus.araddr_o;
      end else begin
        prev_arvalid = 1'b0;
        prev_arready = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the AR handshake; returns just after the handshake edge
  task automatic wait_ar(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.arvalid_o && bus.arready_i) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) tick();
    else check("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_burst(input int err_beat, input int bad_last, input int dis_beat,
                           input int rst_beat, input int bid);
    bit            ok;
    int            wr0;
    logic [DW-1:0] d;
    wait_ar(ok);
    if (!ok) return;
    check("busy_in_burst", 64'(busy), 64'd1);
    wr0 = wr_seen;
    for (int b = 0; b < BL; b++) begin
      if (b == dis_beat) enable = 1'b0;
      d = {32'(bid), 32'hC0DE_0000 | 32'(b)};
      bus.rvalid_i = 1'b1;
      bus.rdata_i  = d;
      bus.rresp_i  = (b == err_beat) ? 2'b10 : 2'b00;
      bus.rlast_i  = (b == BL - 1) || (b == bad_last);
      if (b == rst_beat) begin
        #2 rst = 1'b1;
        #1;
        check("rst_arvalid", 64'(bus.arvalid_o), 64'd0);
        check("rst_rready", 64'(bus.rready_o), 64'd0);
        check("rst_araddr", bus.araddr_o, 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_sel", 64'(wr_sel), 64'd0);
        check("rst_wr_idx", 64'(wr_idx), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_buf_full", 64'(buf_full), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        bus.rvalid_i = 1'b0;
        bus.rlast_i  = 1'b0;
        bus.rresp_i  = 2'b00;
        return;
      end
      if (b != err_beat) begin
        exp_wr[wp] = '{sel: mdl_sel, idx: IW'(b), data: d};
        wp++;
      end
      check("rready_beat", 64'(bus.rready_o), 64'd1);
      tick();
    end
    bus.rvalid_i = 1'b0;
    bus.rlast_i  = 1'b0;
    bus.rresp_i  = 2'b00;
    mdl_sel = ~mdl_sel;
    @(negedge clk);
    #1;
    check("wr_count", 64'(wr_seen - wr0), (err_beat >= 0) ? 64'd31 : 64'd32);
    check("wr_drained", 64'(wp - rp), 64'd0);
    tick();
  endtask

  task automatic release_half(input logic sel, input logic [1:0] exp_full);
    int n;
    release_sel = sel;
    release_p   = 1'b1;
    tick();
    release_p = 1'b0;
    check("full_after_release", 64'(buf_full), 64'(exp_full));
    n = 0;
    while (!bus.arvalid_o && n < 4) begin
      tick();
      n++;
    end
    check("release_latency_le2", 64'(n <= 2), 64'd1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; release_p = 1'b0; release_sel = 1'b0;
    base = 64'h1000; top = 64'h2000;
    bus.arready_i = 1'b1; bus.rvalid_i = 1'b0; bus.rdata_i = '0;
    bus.rresp_i = 2'b00; bus.rlast_i = 1'b0;
    mdl_base = base; mdl_top = top; mdl_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_arvalid", 64'(bus.arvalid_o), 64'd0);
    check("reset_rready", 64'(bus.rready_o), 64'd0);
    check("reset_araddr", bus.araddr_o, 64'd0);
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_buf_full", 64'(buf_full), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    reload_cnt++;
    rst = 1'b0;
    enable = 1'b1;

    // Basic fill: ping then pong, then stall
    run_burst(-1, -1, -1, -1, 1);
    check("full_after_1", 64'(buf_full), 64'b01);
    run_burst(-1, -1, -1, -1, 2);
    check("full_after_2", 64'(buf_full), 64'b11);
    repeat (5) tick();
    check("stall_arvalid", 64'(bus.arvalid_o), 64'd0);
    check("stall_busy", 64'(busy), 64'd0);
    check("addr0_lit", seen_addr[0], 64'h1000);
    check("addr1_lit", seen_addr[1], 64'h1100);

    // Release flow: ping refilled
    release_half(1'b0, 2'b10);
    run_burst(-1, -1, -1, -1, 3);
    check("full_after_refill", 64'(buf_full), 64'b11);
    check("addr2_lit", seen_addr[2], 64'h1200);

    // Response error on beat 5, then stickiness
    release_half(1'b1, 2'b01);
    run_burst(5, -1, -1, -1, 4);
    check("err_after_slverr", 64'(err), 64'd1);
    check("full_after_err", 64'(buf_full), 64'b11);
    release_half(1'b0, 2'b10);
    run_burst(-1, -1, -1, -1, 5);
    check("err_sticky", 64'(err), 64'd1);

    // Disable in IDLE clears flags; switch to a two-burst window
    base = 64'h1000; top = 64'h1200;
    mdl_base = base; mdl_top = top;
    enable = 1'b0;
    repeat (3) tick();
    check("dis_buf_full", 64'(buf_full), 64'd0);
    check("dis_err", 64'(err), 64'd0);
    check("dis_busy", 64'(busy), 64'd0);
    mdl_sel = 1'b0;
    reload_cnt++;

    // AR backpressure, then rlast on beat 30
    bus.arready_i = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 20 && !bus.arvalid_o; i++) tick();
    repeat (10) tick();
    check("bp_arvalid", 64'(bus.arvalid_o), 64'd1);
    check("bp_araddr", bus.araddr_o, 64'h1000);
    bus.arready_i = 1'b1;
    run_burst(-1, 30, -1, -1, 6);
    check("err_after_rlast", 64'(err), 64'd1);
    check("full_after_6", 64'(buf_full), 64'b01);

    // Wrap-around
    run_burst(-1, -1, -1, -1, 7);
    release_half(1'b0, 2'b10);
    run_burst(-1, -1, -1, -1, 8);
    check("addr5_lit", seen_addr[5], 64'h1000);
    check("addr6_lit", seen_addr[6], 64'h1100);
    check("addr7_wrap_lit", seen_addr[7], 64'h1000);

    // Disable at beat 10: burst completes, then everything restarts
    release_half(1'b1, 2'b01);
    run_burst(-1, -1, 10, -1, 9);
    tick();
    check("dismid_buf_full", 64'(buf_full), 64'd0);
    check("dismid_err", 64'(err), 64'd0);
    check("dismid_busy", 64'(busy), 64'd0);
    check("addr8_lit", seen_addr[8], 64'h1100);
    mdl_sel = 1'b0;
    reload_cnt++;
    enable = 1'b1;

    // Async reset at beat 10
    run_burst(-1, -1, -1, 10, 10);
    check("addr9_lit", seen_addr[9], 64'h1000);
    flush_cnt++;
    mdl_sel = 1'b0;
    reload_cnt++;
    tick();
    rst = 1'b0;
    run_burst(-1, -1, -1, -1, 11);
    check("addr10_lit", seen_addr[10], 64'h1000);
    check("full_after_reset", 64'(buf_full), 64'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
